// File: rtl/cache_miss_sequencer.sv
// Read-request front end for the 8-line direct-mapped cache: looks up, fetches from
// memory on a miss, refills the line, and answers the requester with data or error.
module cache_miss_sequencer #(
    parameter int LOOKUP_LAT = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic       CC_clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [7:0] req_addr,
    output logic       req_ready,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_err,
    input  logic       resp_ready,
    output logic       start,
    output logic       read_en,
    output logic [7:0] address,
    input  logic       hit,
    input  logic       miss,
    input  logic [7:0] read_data,
    output logic       write_enable_L1,
    output logic [2:0] write_select,
    output logic [7:0] write_data_L1,
    output logic [5:0] write_data_TA,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [7:0] hit_cnt,
    output logic [7:0] miss_cnt,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MEM_REQ = 3'd2,
        S_REFILL  = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [1:0] LAT_LAST  = 2'(LOOKUP_LAT - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_start;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       r_err;
    logic [1:0] r_lat_cnt;
    logic [7:0] r_wait_cnt;
    logic [2:0] r_wr_sel;
    logic [7:0] r_wr_data;
    logic [5:0] r_wr_tag;
    logic [7:0] r_hit_cnt;
    logic [7:0] r_miss_cnt;

    logic w_accept;
    logic w_hit_done;
    logic w_miss_done;
    logic w_ack;
    logic w_timeout;
    logic w_resp_done;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid holds until that edge. req: requester->us, resp: us->requester.
    // mem_req/mem_ack is a level request answered by a single-cycle ack.
    always_ff @(posedge CC_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        req_ready       = 1'b0;
        read_en         = 1'b0;
        mem_req         = 1'b0;
        write_enable_L1 = 1'b0;
        resp_valid      = 1'b0;
        w_accept        = 1'b0;
        w_hit_done      = 1'b0;
        w_miss_done     = 1'b0;
        w_ack           = 1'b0;
        w_timeout       = 1'b0;
        w_resp_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_start keeps the port closed until the first edge out of reset.
                req_ready = r_start;
                if (req_valid && r_start) begin
                    w_accept = 1'b1;
                    w_next   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                read_en = 1'b1;
                if (r_lat_cnt == 2'd0) begin
                    casez ({hit, miss})
                        2'b1?: begin
                            w_hit_done = 1'b1;
                            w_next     = S_RESP;
                        end
                        default: begin
                            w_miss_done = 1'b1;
                            w_next      = S_MEM_REQ;
                        end
                    endcase
                end
            end
            S_MEM_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_ack  = 1'b1;
                    w_next = S_REFILL;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_REFILL: begin
                write_enable_L1 = 1'b1;
                w_next          = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_resp_done = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CC_clk) begin
        if (rst) begin
            r_start    <= 1'b0;
            r_addr     <= 8'd0;
            r_data     <= 8'd0;
            r_err      <= 1'b0;
            r_lat_cnt  <= 2'd0;
            r_wait_cnt <= 8'd0;
            r_wr_sel   <= 3'd0;
            r_wr_data  <= 8'd0;
            r_wr_tag   <= 6'd0;
            r_hit_cnt  <= 8'd0;
            r_miss_cnt <= 8'd0;
        end else begin
            r_start <= 1'b1;
            if (w_accept) begin
                r_addr    <= req_addr;
                r_lat_cnt <= LAT_LAST;
            end else if (r_state == S_LOOKUP && r_lat_cnt != 2'd0) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            if (w_hit_done) begin
                r_data <= read_data;
                if (r_hit_cnt != 8'hFF) r_hit_cnt <= r_hit_cnt + 8'd1;
            end
            if (w_miss_done) begin
                r_wait_cnt <= 8'd0;
                if (r_miss_cnt != 8'hFF) r_miss_cnt <= r_miss_cnt + 8'd1;
            end else if (r_state == S_MEM_REQ) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // Refill fields are captured at the ack so they are ready in the REFILL cycle.
            if (w_ack) begin
                r_data    <= mem_rdata;
                r_wr_sel  <= r_addr[2:0];
                r_wr_data <= mem_rdata;
                r_wr_tag  <= {1'b1, r_addr[7:3]};
            end
            if (w_timeout) begin
                r_data <= 8'd0;
                r_err  <= 1'b1;
            end
            if (w_resp_done) r_err <= 1'b0;
        end
    end

    assign start         = r_start;
    assign address       = r_addr;
    assign mem_addr      = r_addr;
    assign resp_data     = r_data;
    assign resp_err      = r_err;
    assign write_select  = r_wr_sel;
    assign write_data_L1 = r_wr_data;
    assign write_data_TA = r_wr_tag;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Bench for cache_miss_sequencer: plays cache and memory, predicts each transaction
// from the address-map / timing rules and checks the DUT against that prediction.
module tb_cache_miss_sequencer;

    localparam int LAT = 1;
    localparam int TO  = 16;

    logic       CC_clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = 8'd0;
    logic       req_ready;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_err;
    logic       resp_ready = 1'b0;
    logic       start;
    logic       read_en;
    logic [7:0] address;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [7:0] read_data = 8'd0;
    logic       write_enable_L1;
    logic [2:0] write_select;
    logic [7:0] write_data_L1;
    logic [5:0] write_data_TA;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'd0;
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;
    logic [2:0] o_dbg_state;

    cache_miss_sequencer #(.LOOKUP_LAT(LAT), .TIMEOUT(TO)) dut (
        .CC_clk(CC_clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .resp_ready(resp_ready), .start(start),
        .read_en(read_en), .address(address), .hit(hit), .miss(miss), .read_data(read_data),
        .write_enable_L1(write_enable_L1), .write_select(write_select),
        .write_data_L1(write_data_L1), .write_data_TA(write_data_TA),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .o_dbg_state(o_dbg_state)
    );

    // clock / watchdog
    always #5 CC_clk = ~CC_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard and model state
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [5:0] cc_ta[8];
    logic [7:0] cc_data[8];
    logic [5:0] ref_ta[8];
    logic [7:0] ref_data[8];
    int         ref_hits = 0;
    int         ref_misses = 0;
    logic [2:0] m_ws = 3'd0;
    logic [7:0] m_wd = 8'd0;
    logic [5:0] m_wt = 6'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [5:0] ta, input logic [7:0] d);
        cc_ta[idx] = ta;  cc_data[idx] = d;
        ref_ta[idx] = ta; ref_data[idx] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) @(negedge CC_clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_start", start, 0);
        chk("rst_read_en", read_en, 0);
        chk("rst_address", address, 0);
        chk("rst_wr_en", write_enable_L1, 0);
        chk("rst_wr_sel", write_select, 0);
        chk("rst_wr_data", write_data_L1, 0);
        chk("rst_wr_ta", write_data_TA, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        @(negedge CC_clk);
        chk("post_rst_start", start, 1);
        chk("post_rst_req_ready", req_ready, 1);
    endtask

    // One request; ack_k = mem_req cycle (1-based) carrying the ack, 0 or >TO = never.
    // mode: 0 normal miss flag, 1 miss also raised on hit, 2 neither flag on a miss.
    task automatic run_txn(input logic [7:0] addr, input int ack_k, input logic [7:0] mbyte,
                           input int mode, input int rdly);
        logic [2:0] idx;
        logic [5:0] ent;
        logic [8:0] cur;
        logic       match;
        int exp_lat, exp_mem, exp_wr;
        int cyc, n_rd, n_mem, n_wr, n_resp, lat;
        bit done;
        idx = addr[2:0];
        ent = {1'b1, addr[7:3]};
        cur = 9'd0;
        if (ref_ta[idx] == ent) begin
            exp_q.push_back({1'b0, ref_data[idx]});
            exp_lat = LAT + 1; exp_mem = 0; exp_wr = 0;
            if (ref_hits < 255) ref_hits++;
        end else begin
            if (ref_misses < 255) ref_misses++;
            if (ack_k >= 1 && ack_k <= TO) begin
                exp_q.push_back({1'b0, mbyte});
                exp_lat = LAT + ack_k + 2; exp_mem = ack_k; exp_wr = 1;
                ref_ta[idx] = ent; ref_data[idx] = mbyte;
                m_ws = idx; m_wd = mbyte; m_wt = ent;
            end else begin
                exp_q.push_back(9'h100);
                exp_lat = LAT + TO + 1; exp_mem = TO; exp_wr = 0;
            end
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        cyc = 0; n_rd = 0; n_mem = 0; n_wr = 0; n_resp = 0; lat = 0; done = 0;
        while (!done && cyc < 400) begin
            @(negedge CC_clk);
            cyc++;
            req_valid = 1'b0;
            req_addr  = 8'($urandom);
            chk("req_ready_busy", req_ready, 0);
            if (read_en) begin
                n_rd++;
                chk("lookup_addr", address, addr);
                match = (cc_ta[address[2:0]] == {1'b1, address[7:3]});
                hit = match;
                miss = (mode == 0) ? !match : (mode == 1);
                read_data = match ? cc_data[address[2:0]] : 8'($urandom);
            end else begin
                hit = 1'b0; miss = 1'b0; read_data = 8'($urandom);
            end
            if (mem_req) begin
                n_mem++;
                chk("mem_addr", mem_addr, addr);
                mem_ack   = (n_mem == ack_k);
                mem_rdata = (n_mem == ack_k) ? mbyte : 8'($urandom);
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = 8'($urandom);
            end
            if (write_enable_L1) begin
                n_wr++;
                chk("wr_sel", write_select, idx);
                chk("wr_data", write_data_L1, mbyte);
                chk("wr_ta", write_data_TA, ent);
                cc_ta[write_select]   = write_data_TA;
                cc_data[write_select] = write_data_L1;
            end
            if (resp_valid) begin
                n_resp++;
                if (n_resp == 1) begin
                    lat = cyc;
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    else chk("resp_unexpected", 1, 0);
                end
                chk("resp_data", resp_data, cur[7:0]);
                chk("resp_err", resp_err, cur[8]);
                resp_ready = (n_resp > rdly);
                done = resp_ready;
            end
        end
        if (!done) begin
            chk("txn_no_response", 0, 1);
            exp_q.delete();
        end
        @(negedge CC_clk);
        resp_ready = 1'b0; mem_ack = 1'b0; hit = 1'b0; miss = 1'b0;
        chk("resp_drop", resp_valid, 0);
        chk("err_clear", resp_err, 0);
        chk("back_idle", req_ready, 1);
        chk("latency", lat, exp_lat);
        chk("read_en_cycles", n_rd, LAT);
        chk("mem_req_cycles", n_mem, exp_mem);
        chk("refill_pulses", n_wr, exp_wr);
        chk("wr_sel_hold", write_select, m_ws);
        chk("wr_data_hold", write_data_L1, m_wd);
        chk("wr_ta_hold", write_data_TA, m_wt);
        chk("hit_cnt", hit_cnt, ref_hits);
        chk("miss_cnt", miss_cnt, ref_misses);
    endtask

    // Reset lands while MEM_REQ is waiting; the transaction must vanish.
    task automatic reset_mid_op();
        int n_mem, cyc;
        preload(3'd3, 6'd0, 8'd0);
        req_valid = 1'b1;
        req_addr  = 8'hF3;
        n_mem = 0; cyc = 0;
        while (n_mem < 3 && cyc < 50) begin
            @(negedge CC_clk);
            cyc++;
            req_valid = 1'b0;
            hit = 1'b0;
            miss = read_en;
            mem_ack = 1'b0;
            if (mem_req) n_mem++;
        end
        chk("midop_reached_mem", n_mem, 3);
        miss = 1'b0;
        rst = 1'b1;
        @(negedge CC_clk);
        chk("midop_mem_req", mem_req, 0);
        chk("midop_resp_valid", resp_valid, 0);
        chk("midop_wr_en", write_enable_L1, 0);
        chk("midop_miss_cnt", miss_cnt, 0);
        chk("midop_start", start, 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge CC_clk);
            mem_ack = 1'b1;
            mem_rdata = 8'hEE;
            chk("midop_no_resp", resp_valid, 0);
            chk("midop_no_refill", write_enable_L1, 0);
            chk("midop_no_mem_req", mem_req, 0);
        end
        mem_ack = 1'b0;
        chk("midop_idle", req_ready, 1);
        ref_hits = 0; ref_misses = 0;
        m_ws = 3'd0; m_wd = 8'd0; m_wt = 6'd0;
    endtask

    initial begin
        logic [7:0] pool[16];
        int r, k;
        for (int i = 0; i < 8; i++) preload(3'(i), 6'd0, 8'd0);
        do_reset();

        preload(3'd5, 6'd45, 8'h02);
        run_txn(8'd109, 0, 8'h00, 0, 0);        // hit
        run_txn(8'd104, 3, 8'hA5, 0, 0);        // miss, ack in third wait cycle
        run_txn(8'd200, 0, 8'h00, 0, 0);        // timeout
        run_txn(8'd201, TO, 8'h3C, 0, 0);       // ack in last allowed cycle
        run_txn(8'd109, 0, 8'h00, 0, 10);       // backpressured hit
        run_txn(8'd104, 0, 8'h00, 1, 0);        // hit and miss both high
        run_txn(8'd66, 2, 8'h5A, 2, 0);         // neither flag -> miss path

        for (int i = 0; i < 16; i++) pool[i] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      k = 0;
            else if (r == 1) k = TO;
            else if (r == 2) k = TO + 1;
            else             k = $urandom_range(1, 6);
            run_txn(pool[$urandom_range(0, 15)], k, 8'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 3));
        end

        reset_mid_op();

        preload(3'd6, {1'b1, 5'd21}, 8'h77);
        for (int n = 0; n < 260; n++) run_txn(8'hAE, 0, 8'h00, 0, 0);
        chk("hit_saturated", hit_cnt, 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
